serial_transceiver: RTL and testbench

UART-style serial transceiver: receives 8N1 asynchronous frames on `din` and transmits on `dout` at a fixed baud rate derived from the system clock. With loopback compiled in, every correctly received byte is retransmitted unchanged. The block sits at the board's serial pin pair and exposes the received byte plus status strobes to surrounding logic.

---
 rtl/serial_transceiver_pkg.sv | 23 ++
 rtl/serial_tx_unit.sv | 94 +++++++++
 rtl/serial_transceiver.sv | 155 +++++++++++++++
 tb/tb_serial_transceiver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_transceiver_pkg.sv
// Shared definitions for the serial transceiver: default line timing,
// frame length and the RX/TX state encodings.
package serial_transceiver_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/serial_tx_unit.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each held
// for CLKS_PER_BIT cycles. Only built when SERIAL_TRANSCEIVER_LOOPBACK_EN
// is defined, since nothing else in the block drives the line.
`ifdef SERIAL_TRANSCEIVER_LOOPBACK_EN
module serial_tx_unit
  import serial_transceiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       dout,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  // TX FSM with registered line and busy outputs; load is only honoured in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
      dout  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt <= '0;
          idx <= 3'd0;
          if (load) begin
            shreg <= data;
            dout  <= 1'b0;
            busy  <= 1'b1;
            state <= TX_START;
          end else begin
            dout <= 1'b1;
            busy <= 1'b0;
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            dout  <= shreg[0];
            state <= TX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              dout  <= 1'b1;
              state <= TX_STOP;
            end else begin
              idx   <= idx + 3'd1;
              shreg <= {1'b0, shreg[7:1]};
              dout  <= shreg[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            dout  <= 1'b1;
            busy  <= 1'b0;
            state <= TX_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= TX_IDLE;
          dout  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/serial_transceiver.sv
// UART-style 8N1 transceiver. The receiver, input synchronizer and the
// one-entry loopback holding register live here; the transmitter is
// serial_tx_unit. Define SERIAL_TRANSCEIVER_LOOPBACK_EN to retransmit every
// good byte; otherwise dout is tied high and tx_busy low.
module serial_transceiver
  import serial_transceiver_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  output logic       dout,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_busy,
  output logic       rx_error,
  input  logic       din,
  input  logic       clk,
  input  logic       rst
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_r;
  logic             din_s;
  logic             din_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;

  assign din_s = sync_r[1];

  // Two-flop synchronizer on din plus one flop of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= 2'b11;
      din_prev <= 1'b1;
    end else begin
      sync_r   <= {sync_r[0], din};
      din_prev <= din_s;
    end
  end

  // RX FSM: mid-bit sampling, LSB-first shift, single-cycle status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (din_prev && !din_s) begin
            rx_state <= RX_START;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= 3'd0;
            // A line that is high again at mid-start was only a glitch
            rx_state <= din_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {din_s, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (din_s) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SERIAL_TRANSCEIVER_LOOPBACK_EN
  logic [7:0] hold_data;
  logic       hold_valid;
  logic       tx_load;
  logic [7:0] tx_byte;

  // The held byte is older than a byte arriving now, so it goes out first
  assign tx_load = !tx_busy && (hold_valid || rx_valid);
  assign tx_byte = hold_valid ? hold_data : rx_data;

  // One-entry holding register: newest byte wins, emptied when handed to TX
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (rx_valid && (tx_busy || hold_valid)) begin
      hold_data  <= rx_data;
      hold_valid <= 1'b1;
    end else if (tx_load) begin
      hold_valid <= 1'b0;
    end else begin
      hold_valid <= hold_valid;
    end
  end

  serial_tx_unit #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .data (tx_byte),
    .dout (dout),
    .busy (tx_busy)
  );
`else
  assign dout    = 1'b1;
  assign tx_busy = 1'b0;
`endif

endmodule

// File: tb/tb_serial_transceiver.sv
// Directed self-checking bench for serial_transceiver, run at a reduced
// bit period (16 clocks per bit). Loopback expectations are selected by
// SERIAL_TRANSCEIVER_LOOPBACK_EN, matching the build of the design.
`timescale 1ns/1ps
module tb_serial_transceiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       dout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       rx_error;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int dout_low_cnt = 0;
  int busy_cnt = 0;
  int busy_run = 0;
  int valid_cycs[$];
  int busy_runs[$];
  logic [9:0] tx_frames[$];
  int tx_starts[$];

  logic       tx_act = 1'b0;
  int         tx_cnt = 0;
  int         tx_start_cyc = 0;
  logic [9:0] tx_bits = 10'h000;

  serial_transceiver #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) dut (
    .dout    (dout),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_busy (tx_busy),
    .rx_error(rx_error),
    .din     (din),
    .clk     (clk),
    .rst     (rst)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Line monitor: strobe counters plus an independent decoder of dout
  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cycs.push_back(cyc);
    end
    if (rx_error === 1'b1) err_cnt = err_cnt + 1;
    if (rx_valid === 1'b1 && rx_error === 1'b1) both_cnt = both_cnt + 1;
    if (dout === 1'b0) dout_low_cnt = dout_low_cnt + 1;
    if (tx_busy === 1'b1) begin
      busy_cnt = busy_cnt + 1;
      busy_run = busy_run + 1;
    end else if (busy_run != 0) begin
      busy_runs.push_back(busy_run);
      busy_run = 0;
    end
    if (rst) begin
      tx_act = 1'b0;
    end else if (!tx_act) begin
      if (dout === 1'b0) begin
        tx_act = 1'b1;
        tx_cnt = 0;
        tx_start_cyc = cyc;
      end
    end else begin
      tx_cnt = tx_cnt + 1;
    end
    if (tx_act && (tx_cnt % CPB) == CPB / 2) tx_bits[9 - tx_cnt / CPB] = dout;
    if (tx_act && tx_cnt == 10 * CPB - 1) begin
      tx_frames.push_back(tx_bits);
      tx_starts.push_back(tx_start_cyc);
      tx_act = 1'b0;
    end
  end

  // Drive a 10-bit line pattern, leftmost bit first, CPB cycles per bit
  task automatic send_vec(input logic [9:0] v, output int start_cyc);
    start_cyc = 0;
    for (int i = 9; i >= 0; i--) begin
      @(posedge clk); #1;
      din = v[i];
      if (i == 9) start_cyc = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (dout !== 1'b1) $display("FAIL reset_dout: got %b want 1", dout); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else pass_cnt++;
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++;
    if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b want 0", tx_busy); else pass_cnt++;
    total_cnt++;
    if (rx_error !== 1'b0) $display("FAIL reset_rx_error: got %b want 0", rx_error); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  // One good frame: data, strobe counts, latency and (with loopback) echo
  task automatic test_frame(input string name, input logic [9:0] v, input logic [7:0] exp_byte,
                            input int idle_before);
    int v0, e0, d0, b0, f0, r0, st, lat;
    logic [9:0] got;
    repeat (idle_before) @(posedge clk);
    v0 = valid_cnt; e0 = err_cnt; d0 = dout_low_cnt; b0 = busy_cnt;
    f0 = tx_frames.size(); r0 = busy_runs.size();
    send_vec(v, st);
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (valid_cnt - v0 !== 1) $display("FAIL %s_valid_count: got %0d want 1", name, valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== exp_byte) $display("FAIL %s_rx_data: got %h want %h", name, rx_data, exp_byte); else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 !== 0) $display("FAIL %s_no_error: got %0d errors want 0", name, err_cnt - e0); else pass_cnt++;
    lat = (valid_cnt > v0) ? valid_cycs[v0] - st : -1;
    total_cnt++;
    if (lat < 2 + CPB / 2 + 9 * CPB - 1 || lat > 2 + CPB / 2 + 9 * CPB + 1)
      $display("FAIL %s_rx_latency: got %0d want %0d +-1", name, lat, 2 + CPB / 2 + 9 * CPB);
    else pass_cnt++;
`ifdef SERIAL_TRANSCEIVER_LOOPBACK_EN
    got = (tx_frames.size() > f0) ? tx_frames[f0] : 10'h3FF;
    total_cnt++;
    if (got !== v) $display("FAIL %s_echo_bits: got %b want %b", name, got, v); else pass_cnt++;
    total_cnt++;
    if (tx_frames.size() > f0 && valid_cnt > v0 && tx_starts[f0] - valid_cycs[v0] == 1) pass_cnt++;
    else $display("FAIL %s_echo_start: tx start not 1 cycle after rx_valid (frames %0d)", name, tx_frames.size() - f0);
    total_cnt++;
    if (busy_runs.size() <= r0 || busy_runs[r0] != 10 * CPB)
      $display("FAIL %s_busy_len: got %0d want %0d", name, (busy_runs.size() > r0) ? busy_runs[r0] : 0, 10 * CPB);
    else pass_cnt++;
`else
    got = v;
    total_cnt++;
    if (dout_low_cnt - d0 !== 0) $display("FAIL %s_dout_idle: got %0d low cycles want 0", name, dout_low_cnt - d0); else pass_cnt++;
    total_cnt++;
    if (busy_cnt - b0 !== 0) $display("FAIL %s_busy_idle: got %0d busy cycles want 0", name, busy_cnt - b0); else pass_cnt++;
`endif
  endtask

  task automatic test_hold_after();
    repeat (50) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (rx_data !== 8'h8E) $display("FAIL hold_rx_data: got %h want 8e", rx_data); else pass_cnt++;
  endtask

  task automatic test_framing_error();
    int v0, e0, d0, st;
    v0 = valid_cnt; e0 = err_cnt; d0 = dout_low_cnt;
    send_vec(10'b0101010100, st);
    @(posedge clk); #1;
    din = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (err_cnt - e0 !== 1) $display("FAIL ferr_error_count: got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h8E) $display("FAIL ferr_rx_data: got %h want 8e", rx_data); else pass_cnt++;
    total_cnt++;
    if (dout_low_cnt - d0 !== 0) $display("FAIL ferr_dout_idle: got %0d low cycles want 0", dout_low_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    din = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (valid_cnt - v0 !== 0) $display("FAIL glitch_no_valid: got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (err_cnt - e0 !== 0) $display("FAIL glitch_no_error: got %0d want 0", err_cnt - e0); else pass_cnt++;
    test_frame("after_glitch", 10'b0101001011, 8'hA5, 0);
  endtask

  task automatic test_back_to_back();
    int v0, f0, d0, st;
    logic [9:0] exp_v[3];
    logic [7:0] exp_b[3];
    logic [9:0] got;
    exp_v[0] = 10'b0100000001; exp_b[0] = 8'h01;
    exp_v[1] = 10'b0010000001; exp_b[1] = 8'h02;
    exp_v[2] = 10'b0110000001; exp_b[2] = 8'h03;
    v0 = valid_cnt; f0 = tx_frames.size();
    for (int i = 0; i < 3; i++) send_vec(exp_v[i], st);
    repeat (14 * CPB) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (valid_cnt - v0 !== 3) $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h03) $display("FAIL b2b_last_data: got %h want 03", rx_data); else pass_cnt++;
`ifdef SERIAL_TRANSCEIVER_LOOPBACK_EN
    for (int i = 0; i < 3; i++) begin
      got = (tx_frames.size() > f0 + i) ? tx_frames[f0 + i] : 10'h3FF;
      total_cnt++;
      if (got !== exp_v[i]) $display("FAIL b2b_echo_%0d: got %b want %b (byte %h)", i, got, exp_v[i], exp_b[i]);
      else pass_cnt++;
    end
`endif
    // Two more frames; reset lands halfway through the second echo
    send_vec(10'b0001000001, st);
    send_vec(10'b0101000001, st);
    repeat (77) @(posedge clk);
    @(negedge clk);
`ifdef SERIAL_TRANSCEIVER_LOOPBACK_EN
    total_cnt++;
    if (tx_busy !== 1'b1) $display("FAIL b2b_busy_before_rst: got %b want 1", tx_busy); else pass_cnt++;
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (dout !== 1'b1) $display("FAIL rst_mid_dout: got %b want 1", dout); else pass_cnt++;
    total_cnt++;
    if (tx_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", tx_busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = valid_cnt; f0 = tx_frames.size(); d0 = dout_low_cnt;
    repeat (20 * CPB) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (dout_low_cnt - d0 !== 0) $display("FAIL rst_mid_no_output: got %0d low cycles want 0", dout_low_cnt - d0); else pass_cnt++;
    total_cnt++;
    if (tx_frames.size() - f0 !== 0) $display("FAIL rst_mid_no_frames: got %0d want 0", tx_frames.size() - f0); else pass_cnt++;
    total_cnt++;
    if (valid_cnt - v0 !== 0) $display("FAIL rst_mid_no_valid: got %0d want 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame("good_63", 10'b0110001101, 8'h63, 0);
    test_frame("second_8e", 10'b0011100011, 8'h8E, 600);
    test_hold_after();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL valid_error_overlap: got %0d cycles want 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
